// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART command receiver:
//                receiver FSM states, default bit period and the command
//                codes understood by the downstream consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // 50 MHz system clock, 9600 baud
    localparam int unsigned c_CLKS_PER_BIT_DEFAULT = 5208;

    // Command nibbles acted upon by the consumer; the receiver does not filter
    localparam logic [3:0] LIMPAR   = 4'd1;
    localparam logic [3:0] CARREGAR = 4'd2;
    localparam logic [3:0] MOSTRAR  = 4'd4;

endpackage
`default_nettype wire

// File: rtl/sincroniza_rx.sv
`default_nettype none
// ============================================================================
//  Module      : sincroniza_rx
//  Description : Two-flop synchronizer for the asynchronous serial line.
//                Resets to 1 so a reset never looks like a start bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module sincroniza_rx (
    input  logic clock,
    input  logic reset,
    input  logic i_rx,
    output logic o_rx_s
);

    logic [1:0] r_sync;

    // Shift the raw line through two flops to settle metastability
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_rx};
        end
    end

    assign o_rx_s = r_sync[1];

endmodule
`default_nettype wire

// File: rtl/uart_rx_cmd.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_cmd
//  Description : 8N1 UART receiver that splits each good byte into a command
//                nibble (bits 7:4) and a data nibble (bits 3:0). Flags
//                framing errors and holds its outputs between good frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cmd
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [3:0] instrucao,
    output logic [3:0] dado,
    output logic       valido,
    output logic       erro,
    output logic       ocupado
);

    localparam int unsigned     c_TW        = $clog2(CLKS_PER_BIT);
    localparam logic [c_TW-1:0] c_BIT_LAST  = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0] c_HALF_LAST = c_TW'(CLKS_PER_BIT / 2 - 1);

    logic            w_rx_s;
    uart_state_t     r_state;
    logic [c_TW-1:0] r_timer;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic [3:0]      r_instrucao;
    logic [3:0]      r_dado;
    logic            r_valido;
    logic            r_erro;
    logic            r_ocupado;
    // Set by a framing error: the line must return high before a new start
    // is accepted, so a held break reports only one error.
    logic            r_brk;

    sincroniza_rx u_sincroniza_rx (
        .clock  (clock),
        .reset  (reset),
        .i_rx   (rx),
        .o_rx_s (w_rx_s)
    );

    // Receiver FSM: start detection, mid-bit sampling, stop check and outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_instrucao <= '0;
            r_dado      <= '0;
            r_valido    <= 1'b0;
            r_erro      <= 1'b0;
            r_ocupado   <= 1'b0;
            r_brk       <= 1'b0;
        end else begin
            r_valido <= 1'b0;
            r_erro   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rx_s) begin
                        r_brk <= 1'b0;
                    end else if (!r_brk) begin
                        r_state   <= START;
                        r_timer   <= '0;
                        r_ocupado <= 1'b1;
                    end
                end
                START: begin
                    if (r_timer == c_HALF_LAST) begin
                        r_timer <= '0;
                        if (!w_rx_s) begin
                            r_state <= DATA;
                            r_idx   <= '0;
                        end else begin
                            // Glitch shorter than half a bit: drop silently
                            r_state   <= IDLE;
                            r_ocupado <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DATA: begin
                    if (r_timer == c_BIT_LAST) begin
                        r_timer <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_idx == 3'd7) begin
                            r_state <= STOP;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                STOP: begin
                    if (r_timer == c_BIT_LAST) begin
                        r_timer   <= '0;
                        r_state   <= IDLE;
                        r_ocupado <= 1'b0;
                        if (w_rx_s) begin
                            r_instrucao <= r_shift[7:4];
                            r_dado      <= r_shift[3:0];
                            r_valido    <= 1'b1;
                        end else begin
                            r_erro <= 1'b1;
                            r_brk  <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_timer   <= '0;
                    r_ocupado <= 1'b0;
                end
            endcase
        end
    end

    assign instrucao = r_instrucao;
    assign dado      = r_dado;
    assign valido    = r_valido;
    assign erro      = r_erro;
    assign ocupado   = r_ocupado;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cmd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_cmd
//  Description : Scoreboard testbench for uart_rx_cmd (CLKS_PER_BIT = 16).
//                Stimulus pushes expected results; a monitor pops and checks
//                them whenever the receiver pulses valido or erro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cmd;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       rx;
    logic [3:0] instrucao;
    logic [3:0] dado;
    logic       valido;
    logic       erro;
    logic       ocupado;

    typedef struct {
        bit         is_err;
        logic [3:0] ins;
        logic [3:0] dat;
        int         t0;
    } exp_t;

    exp_t sb[$];
    int   pulse_cyc[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model of what instrucao/dado should currently hold
    logic [3:0] m_ins = 4'd0;
    logic [3:0] m_dat = 4'd0;

    logic [3:0] prev_ins  = 4'd0;
    logic [3:0] prev_dat  = 4'd0;
    logic       prev_ocup = 1'b0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    uart_rx_cmd #(.CLKS_PER_BIT(CPB)) dut (
        .clock     (clock),
        .reset     (reset),
        .rx        (rx),
        .instrucao (instrucao),
        .dado      (dado),
        .valido    (valido),
        .erro      (erro),
        .ocupado   (ocupado)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: compares every output pulse against the scoreboard head
    always @(negedge clock) begin
        exp_t e;
        int   d;
        if (!reset) begin
            check("valido_erro_exclusive", {31'd0, valido & erro}, 32'd0);
            if (!valido) begin
                check("hold_instrucao", {28'd0, instrucao}, {28'd0, prev_ins});
                check("hold_dado", {28'd0, dado}, {28'd0, prev_dat});
            end
            if (valido || erro) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    d = cyc - e.t0;
                    check("pulse_kind", {30'd0, valido, erro}, e.is_err ? 32'd1 : 32'd2);
                    check("out_instrucao", {28'd0, instrucao}, {28'd0, e.ins});
                    check("out_dado", {28'd0, dado}, {28'd0, e.dat});
                    check("pulse_in_stop_bit", {31'd0, (d >= 9*CPB) && (d <= 10*CPB + 3)}, 32'd1);
                    check("ocupado_falls", {30'd0, prev_ocup, ocupado}, 32'd2);
                end
                if (valido) pulse_cyc.push_back(cyc);
            end
        end
        prev_ins  = instrucao;
        prev_dat  = dado;
        prev_ocup = ocupado;
    end

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        exp_t e;
        e.t0 = cyc;
        if (stop_ok) begin
            e.is_err = 1'b0;
            e.ins    = b[7:4];
            e.dat    = b[3:0];
            m_ins    = b[7:4];
            m_dat    = b[3:0];
        end else begin
            e.is_err = 1'b1;
            e.ins    = m_ins;
            e.dat    = m_dat;
        end
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        rx = 1'b1;
        // After a bad stop the line must go high before the next start counts
        if (!stop_ok) drive_bit(1'b1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 40*CPB) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("drain_timeout", 32'(sb.size()), 32'd0);
        repeat (4) @(posedge clock);
        #1;
    endtask

    initial begin
        exp_t eb;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("reset_instrucao", {28'd0, instrucao}, 32'd0);
        check("reset_dado", {28'd0, dado}, 32'd0);
        check("reset_flags", {29'd0, valido, erro, ocupado}, 32'd0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;

        // Single good frame 0x24, plus busy flag in mid-frame
        fork
            send_frame(8'h24, 1'b1);
            begin
                repeat (5*CPB) @(posedge clock);
                #1;
                check("ocupado_mid_frame", {31'd0, ocupado}, 32'd1);
            end
        join
        wait_drain();

        // Back-to-back frames, no idle gap
        pulse_cyc.delete();
        send_frame(8'h15, 1'b1);
        send_frame(8'h40, 1'b1);
        wait_drain();
        check("b2b_pulse_count", 32'(pulse_cyc.size()), 32'd2);
        if (pulse_cyc.size() == 2)
            check("b2b_spacing", 32'(pulse_cyc[1] - pulse_cyc[0]), 32'(10*CPB));

        // Short glitch: no pulse, back to idle quickly
        rx = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("glitch_busy", {31'd0, ocupado}, 32'd1);
        rx = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        check("glitch_idle", {31'd0, ocupado}, 32'd0);
        repeat (2*CPB) @(posedge clock);
        #1;

        // Good frame then framing error: outputs retained
        send_frame(8'h24, 1'b1);
        send_frame(8'h3F, 1'b0);
        wait_drain();
        check("retain_instrucao", {28'd0, instrucao}, 32'd2);
        check("retain_dado", {28'd0, dado}, 32'd4);

        // Reset in the middle of data bit 3
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'(8'h24 >> i));
        rx = 1'b0;
        repeat (CPB/2) @(posedge clock);
        #1;
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        check("abort_reset_outputs", {23'd0, instrucao, dado, valido, erro, ocupado}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        m_ins = 4'd0;
        m_dat = 4'd0;
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_frame(8'h11, 1'b1);
        wait_drain();

        // Break: 30 bit times low -> exactly one error, then a good frame
        eb.is_err = 1'b1;
        eb.ins    = m_ins;
        eb.dat    = m_dat;
        eb.t0     = cyc;
        sb.push_back(eb);
        rx = 1'b0;
        repeat (30*CPB) @(posedge clock);
        #1;
        drive_bit(1'b1);
        drive_bit(1'b1);
        send_frame(8'h42, 1'b1);
        wait_drain();
        check("break_final_instrucao", {28'd0, instrucao}, 32'd4);
        check("break_final_dado", {28'd0, dado}, 32'd2);

        // Randomized frames with random stop bits and gaps
        for (int k = 0; k < 16; k++) begin
            logic [7:0] b;
            logic       ok;
            int         gap;
            b   = 8'($urandom);
            ok  = ($urandom_range(3) != 0);
            gap = $urandom_range(2);
            send_frame(b, ok);
            for (int g = 0; g < gap; g++) drive_bit(1'b1);
        end
        wait_drain();
        check("final_instrucao", {28'd0, instrucao}, {28'd0, m_ins});
        check("final_dado", {28'd0, dado}, {28'd0, m_dat});
        check("final_idle", {31'd0, ocupado}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_cmd.md
UART_RX_CMD -- requirements
Module: uart_rx_cmd

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 8 or more.
REQ-002 clock  input  1  single system clock, all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx  input  1  serial line, 8N1, idle high, LSB first, asynchronous to clock.
REQ-005 instrucao  output  4  command nibble = received byte bits [7:4].
REQ-006 dado  output  4  data nibble = received byte bits [3:0].
REQ-007 valido  output  1  one-cycle pulse; instrucao/dado hold a new, good frame.
REQ-008 erro  output  1  one-cycle pulse; framing error (stop bit sampled low).
REQ-009 ocupado  output  1  high while a frame is being received (state other than IDLE).

Function
REQ-010 rx SHALL pass through a two-flop synchronizer before any use; all timing below is relative to the synchronized signal (rx_s).
REQ-011 FSM states: IDLE, START, DATA, STOP.
REQ-012 IDLE: on rx_s = 0, go to START and clear the bit-timer.
REQ-013 START: sample rx_s when the timer reaches CLKS_PER_BIT/2 - 1 (integer division). If 0, go to DATA with the timer and bit index cleared; if 1 (glitch), return to IDLE with no output activity.
REQ-014 DATA: sample one bit every CLKS_PER_BIT cycles into an 8-bit shift register, LSB first; after bit index 7, go to STOP.
REQ-015 STOP: sample rx_s after CLKS_PER_BIT cycles, then return to IDLE.
REQ-016 Good stop bit (1): next cycle, instrucao <= byte[7:4], dado <= byte[3:0], valido = 1 for exactly one cycle.
REQ-017 Bad stop bit (0): next cycle, erro = 1 for exactly one cycle; instrucao/dado keep their previous values and valido stays 0.
REQ-018 instrucao/dado SHALL be held stable between valido pulses; they never change without valido.
REQ-019 No command filtering: every 4-bit value, including codes the consumer ignores, is delivered.
REQ-020 valido and erro SHALL never be high in the same cycle.
REQ-021 After STOP, IDLE SHALL accept a new start edge on the very next cycle, so back-to-back frames with no idle gap are received without loss.
REQ-022 Bit-timer width is clog2(CLKS_PER_BIT); the bit index is 3 bits; neither counter wraps, because both are cleared on every state transition.
REQ-023 A line held low (break) SHALL produce erro once, then the FSM stays in IDLE until rx_s returns high and falls again.

Reset
REQ-024 On reset assertion, immediately: state = IDLE, instrucao = 0, dado = 0, valido = 0, erro = 0, ocupado = 0, counters and shift register = 0, synchronizer flops = 1.
REQ-025 Reset during a frame SHALL abandon the frame with no valido or erro pulse; reception resumes at the first falling edge after release.

Structure
REQ-026 Shared package uart_pkg SHALL hold: the state enum, the default CLKS_PER_BIT, and the command codes LIMPAR = 1, CARREGAR = 2, MOSTRAR = 4 used by the command consumer.
REQ-027 One sub-module, sincroniza_rx (two-flop synchronizer, reset value 1), is instantiated for rx; all other logic is in a single FSM process.

Verification (CLKS_PER_BIT = 16)
REQ-028 Send byte 0x24 with a good stop bit -> one valido pulse, instrucao = 2, dado = 4, erro stays 0, ocupado falls with valido.
REQ-029 Send 0x15 then 0x40 back-to-back with no idle gap -> two valido pulses 160 cycles apart, outputs 1/5 then 4/0.
REQ-030 Drive rx low for 5 cycles, then high -> no valido, no erro, FSM back in IDLE by cycle 10.
REQ-031 Send 0x24, then 0x3F with a stop bit of 0 -> erro pulses once; instrucao = 2 and dado = 4 are retained.
REQ-032 Assert reset at data bit 3 of 0x24, release, then send 0x11 -> no pulse for the aborted frame; one valido with instrucao = 1, dado = 1.
REQ-033 Hold rx low for 30 bit times, then release and send 0x42 -> exactly one erro during the break, then valido with instrucao = 4, dado = 2.
